gpr_access_seq: RTL and testbench

Sequencer that sits directly upstream of the three-port GPR environment and owns its control inputs. Accepts one write request and/or one three-operand read request per transaction, drives the GPR write cycle first (write-before-read), then the read cycle, and registers the GPR read outputs (A, B, D, AEQZ) into stable holding registers for the pipeline. Needed because the GPR shares its RAM address lines between write and read: a write cycle cannot also deliver reads.

---
 rtl/gpr_seq_pkg.sv | 15 +
 rtl/gpr_req_latch.sv | 53 +++++
 rtl/gpr_access_seq.sv | 98 +++++++++
 tb/tb_gpr_access_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gpr_seq_pkg.sv
// Shared definitions for the GPR access sequencer: datapath widths and the
// sequencer state encoding.
package gpr_seq_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

endpackage

// File: rtl/gpr_req_latch.sv
// Request holding register: captures the write/read fields and pending flags
// of an accepted request and presents them to the GPR until the next accept.
module gpr_req_latch
  import gpr_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic                  wr_req,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_req,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  input  logic [REG_ADDR_W-1:0] rd_d_addr,
  output logic                  wr_pend,
  output logic                  rd_pend,
  output logic [REG_ADDR_W-1:0] wr_addr_q,
  output logic [DATA_W-1:0]     wr_data_q,
  output logic [REG_ADDR_W-1:0] rd_a_addr_q,
  output logic [REG_ADDR_W-1:0] rd_b_addr_q,
  output logic [REG_ADDR_W-1:0] rd_d_addr_q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_a_addr_q <= '0;
      rd_b_addr_q <= '0;
      rd_d_addr_q <= '0;
    end else if (accept) begin
      wr_pend <= wr_req;
      rd_pend <= rd_req;
      // Only the half of the request that is asserted is refreshed, so the
      // GPR address/data lines keep their last meaningful values.
      if (wr_req) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      if (rd_req) begin
        rd_a_addr_q <= rd_a_addr;
        rd_b_addr_q <= rd_b_addr;
        rd_d_addr_q <= rd_d_addr;
      end
    end
  end

endmodule

// File: rtl/gpr_access_seq.sv
// GPR access sequencer: runs the write cycle before the read cycle of each
// accepted request and holds the captured read operands for the pipeline.
module gpr_access_seq
  import gpr_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  req_ready,
  input  logic                  wr_req,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_req,
  input  logic [REG_ADDR_W-1:0] rd_a_addr,
  input  logic [REG_ADDR_W-1:0] rd_b_addr,
  input  logic [REG_ADDR_W-1:0] rd_d_addr,
  output logic                  wr_done,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     a_q,
  output logic [DATA_W-1:0]     b_q,
  output logic [DATA_W-1:0]     d_q,
  output logic                  aeqz_q,
  output logic                  gpr_we,
  output logic [DATA_W-1:0]     gpr_c,
  output logic [REG_ADDR_W-1:0] gpr_a_addr,
  output logic [REG_ADDR_W-1:0] gpr_b_addr,
  output logic [REG_ADDR_W-1:0] gpr_c_addr,
  output logic [REG_ADDR_W-1:0] gpr_d_addr,
  input  logic [DATA_W-1:0]     gpr_a,
  input  logic [DATA_W-1:0]     gpr_b,
  input  logic [DATA_W-1:0]     gpr_d,
  input  logic                  gpr_aeqz
);

  state_t state;
  logic   accept;
  logic   wr_pend;
  logic   rd_pend;

  assign accept    = (state == ST_IDLE) && (wr_req || rd_req);
  // Pure state decodes: an async reset drops the write enable immediately.
  assign req_ready = (state == ST_IDLE);
  assign gpr_we    = (state == ST_WRITE);

  gpr_req_latch u_req_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept      (accept),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .rd_a_addr   (rd_a_addr),
    .rd_b_addr   (rd_b_addr),
    .rd_d_addr   (rd_d_addr),
    .wr_pend     (wr_pend),
    .rd_pend     (rd_pend),
    .wr_addr_q   (gpr_c_addr),
    .wr_data_q   (gpr_c),
    .rd_a_addr_q (gpr_a_addr),
    .rd_b_addr_q (gpr_b_addr),
    .rd_d_addr_q (gpr_d_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      aeqz_q   <= 1'b0;
    end else begin
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_req)      state <= ST_WRITE;
          else if (rd_req) state <= ST_READ;
        end
        ST_WRITE: begin
          wr_done <= wr_pend;
          state   <= rd_pend ? ST_READ : ST_IDLE;
        end
        ST_READ: begin
          rd_valid <= 1'b1;
          a_q      <= gpr_a;
          b_q      <= gpr_b;
          d_q      <= gpr_d;
          aeqz_q   <= gpr_aeqz;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_access_seq.sv
// Directed bench for gpr_access_seq: a behavioural GPR model, a table of
// request vectors, and hand-written held-request and mid-write reset cases.
module tb_gpr_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_ready;
  logic        wr_req;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [4:0]  rd_a_addr, rd_b_addr, rd_d_addr;
  logic        wr_done, rd_valid;
  logic [31:0] a_q, b_q, d_q;
  logic        aeqz_q;
  logic        gpr_we;
  logic [31:0] gpr_c;
  logic [4:0]  gpr_a_addr, gpr_b_addr, gpr_c_addr, gpr_d_addr;
  logic [31:0] gpr_a, gpr_b, gpr_d;
  logic        gpr_aeqz;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gpr_access_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ready  (req_ready),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_a_addr  (rd_a_addr),
    .rd_b_addr  (rd_b_addr),
    .rd_d_addr  (rd_d_addr),
    .wr_done    (wr_done),
    .rd_valid   (rd_valid),
    .a_q        (a_q),
    .b_q        (b_q),
    .d_q        (d_q),
    .aeqz_q     (aeqz_q),
    .gpr_we     (gpr_we),
    .gpr_c      (gpr_c),
    .gpr_a_addr (gpr_a_addr),
    .gpr_b_addr (gpr_b_addr),
    .gpr_c_addr (gpr_c_addr),
    .gpr_d_addr (gpr_d_addr),
    .gpr_a      (gpr_a),
    .gpr_b      (gpr_b),
    .gpr_d      (gpr_d),
    .gpr_aeqz   (gpr_aeqz)
  );

  // GPR environment model: R0 reads zero and ignores writes.
  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = 32'h0;
  always @(posedge clk) if (gpr_we && gpr_c_addr != 5'd0) regs[gpr_c_addr] <= gpr_c;
  assign gpr_a    = regs[gpr_a_addr];
  assign gpr_b    = regs[gpr_b_addr];
  assign gpr_d    = regs[gpr_d_addr];
  assign gpr_aeqz = (gpr_a == 32'h0);

  typedef struct {
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [4:0]  a, b, d;
    logic [31:0] ea, eb, ed;
    logic        eaeqz;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Issues one request and observes five cycles after acceptance.
  task automatic run_vec(input vec_t v, input int idx);
    int n_we = 0, we_cyc = 0, n_done = 0, done_cyc = 0, n_valid = 0, valid_cyc = 0, busy = 0;
    logic [4:0]  we_addr = '0;
    logic [31:0] we_data = '0, ca = '0, cb = '0, cd = '0;
    logic        caeqz = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), req_ready, 1);
    wr_req = v.wr; wr_addr = v.waddr; wr_data = v.wdata;
    rd_req = v.rd; rd_a_addr = v.a; rd_b_addr = v.b; rd_d_addr = v.d;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin wr_req = 1'b0; rd_req = 1'b0; end
      if (gpr_we) begin n_we++; we_cyc = c; we_addr = gpr_c_addr; we_data = gpr_c; end
      if (wr_done) begin n_done++; done_cyc = c; end
      if (rd_valid) begin
        n_valid++; valid_cyc = c; ca = a_q; cb = b_q; cd = d_q; caeqz = aeqz_q;
      end
      if (!req_ready) busy++;
    end
    check($sformatf("v%0d busy_cycles", idx), busy, (v.wr && v.rd) ? 2 : 1);
    check($sformatf("v%0d we_count", idx), n_we, v.wr ? 1 : 0);
    check($sformatf("v%0d done_count", idx), n_done, v.wr ? 1 : 0);
    check($sformatf("v%0d valid_count", idx), n_valid, v.rd ? 1 : 0);
    if (v.wr) begin
      check($sformatf("v%0d we_cycle", idx), we_cyc, 1);
      check($sformatf("v%0d done_cycle", idx), done_cyc, 2);
      check($sformatf("v%0d c_addr", idx), we_addr, v.waddr);
      check($sformatf("v%0d c_data", idx), we_data, v.wdata);
    end
    if (v.rd) begin
      check($sformatf("v%0d valid_cycle", idx), valid_cyc, v.wr ? 3 : 2);
      check($sformatf("v%0d a_q", idx), ca, v.ea);
      check($sformatf("v%0d b_q", idx), cb, v.eb);
      check($sformatf("v%0d d_q", idx), cd, v.ed);
      check($sformatf("v%0d aeqz_q", idx), caeqz, v.eaeqz);
      check($sformatf("v%0d a_q_held", idx), a_q, v.ea);
    end
  endtask

  initial begin
    int n_valid;
    int n_done;
    logic [31:0] va, vb, vd;
    vec_t rv;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 5'd7,  32'h00000000, 1'b1, 5'd7,  5'd5,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,  5'd7,  32'h0, 32'hDEADBEEF, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 5'd3,  32'h000000A5, 1'b1, 5'd3,  5'd3,  5'd5,  32'hA5, 32'hA5, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd31, 5'd3,  32'hDEADBEEF, 32'h0, 32'hA5, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd0,  5'd31, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b0};

    rst_n = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_a_addr = '0; rd_b_addr = '0; rd_d_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst req_ready", req_ready, 1);
    check("rst gpr_we", gpr_we, 0);
    check("rst wr_done", wr_done, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst a_q", a_q, 0);
    check("rst b_q", b_q, 0);
    check("rst d_q", d_q, 0);
    check("rst aeqz_q", aeqz_q, 0);
    check("rst gpr_c", gpr_c, 0);
    check("rst addrs", {gpr_a_addr, gpr_b_addr, gpr_c_addr, gpr_d_addr}, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Read request raised during WRITE must wait for IDLE and be taken once.
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    @(negedge clk);
    check("held we_in_write", gpr_we, 1);
    wr_req = 1'b0;
    rd_req = 1'b1; rd_a_addr = 5'd9; rd_b_addr = 5'd5; rd_d_addr = 5'd3;
    n_valid = 0; va = '0; vb = '0; vd = '0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("held ready_after_write", req_ready, 1);
        check("held wr_done", wr_done, 1);
      end
      if (c == 3) begin
        check("held ready_in_read", req_ready, 0);
        rd_req = 1'b0;
      end
      if (rd_valid) begin n_valid++; va = a_q; vb = b_q; vd = d_q; end
    end
    check("held valid_count", n_valid, 1);
    check("held a_q", va, 32'h11);
    check("held b_q", vb, 32'hDEADBEEF);
    check("held d_q", vd, 32'hA5);

    // Reset asserted mid-WRITE: write enable drops before the edge, no done.
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
    @(negedge clk);
    wr_req = 1'b0;
    check("rstw we_before", gpr_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw we_async", gpr_we, 0);
    check("rstw req_ready", req_ready, 1);
    check("rstw a_q_cleared", a_q, 0);
    check("rstw c_addr_cleared", gpr_c_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_done) n_done++;
    end
    check("rstw no_done", n_done, 0);
    rv = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd9, 5'd0, 32'hDEADBEEF, 32'h11, 32'h0, 1'b0};
    run_vec(rv, 99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
